// File: rtl/autosym_eval.sv
// GF(2) linear projection of x onto K bits followed by a 2^K-entry truth-table lookup.
// Two-stage valid/ready pipeline; configuration is applied only while the pipeline is empty.
module autosym_eval #(
  parameter  int N  = 6,
  parameter  int K  = 3,
  parameter  int CW = 16,
  localparam int AW = (K > 1) ? $clog2(K) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  x,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          y,
  input  logic          cfg_row_we,
  input  logic [AW-1:0] cfg_row_addr,
  input  logic [N-1:0]  cfg_row_data,
  input  logic          cfg_tt_we,
  input  logic [K-1:0]  cfg_tt_addr,
  input  logic          cfg_tt_data,
  input  logic          cfg_inv_we,
  input  logic          cfg_inv_data,
  output logic          cfg_ready,
  output logic [CW-1:0] ones_count
);

  generate
    if (K < 1 || K > N) begin : g_bad_k
      $error("autosym_eval: K must satisfy 1 <= K <= N");
    end
  endgenerate

  logic [K-1:0][N-1:0] row_q;
  logic [(1<<K)-1:0]   tt_q;
  logic                inv_q;
  logic                s1_vld_q, s2_vld_q;
  logic [K-1:0]        z_q, z_d;
  logic                y_q, y_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                cfg_pending, cfg_fire, in_fire, out_fire;
  logic                s1_adv, s2_adv;

  // Each projected bit is the parity of the row-masked input.
  generate
    for (genvar j = 0; j < K; j++) begin : g_proj
      assign z_d[j] = ^(row_q[j] & x);
    end
  endgenerate

  assign y_d         = tt_q[z_q] ^ inv_q;
  assign cfg_pending = cfg_row_we | cfg_tt_we | cfg_inv_we;
  assign s2_adv      = !s2_vld_q | out_ready;
  assign s1_adv      = !s1_vld_q | s2_adv;
  // Reset gating keeps both handshakes low for the whole reset assertion.
  assign in_ready    = rst_n & !cfg_pending & s1_adv;
  assign cfg_ready   = rst_n & !s1_vld_q & !s2_vld_q;
  assign in_fire     = in_valid & in_ready;
  assign cfg_fire    = cfg_pending & cfg_ready;
  assign out_fire    = s2_vld_q & out_ready;

  assign cnt_d = (out_fire && y_q && cnt_q != {CW{1'b1}}) ? cnt_q + CW'(1) : cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < K; j++) row_q[j] <= N'(1) << j;
      tt_q  <= '0;
      inv_q <= 1'b0;
    end else if (cfg_fire) begin
      for (int j = 0; j < K; j++)
        if (cfg_row_we && cfg_row_addr == AW'(j)) row_q[j] <= cfg_row_data;
      if (cfg_tt_we)  tt_q[cfg_tt_addr] <= cfg_tt_data;
      if (cfg_inv_we) inv_q <= cfg_inv_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q <= 1'b0;
      s2_vld_q <= 1'b0;
      z_q      <= '0;
      y_q      <= 1'b0;
      cnt_q    <= '0;
    end else begin
      if (s1_adv) begin
        s1_vld_q <= in_fire;
        if (in_fire) z_q <= z_d;
      end
      if (s2_adv) begin
        s2_vld_q <= s1_vld_q;
        if (s1_vld_q) y_q <= y_d;
      end
      cnt_q <= cnt_d;
    end
  end

  assign out_valid  = s2_vld_q;
  assign y          = y_q;
  assign ones_count = cnt_q;

endmodule

// File: tb/tb_autosym_eval.sv
// Directed bench for autosym_eval: a spec-level model (config arrays plus an expected-result
// queue) is checked every cycle, alongside hand-computed literal expectations.
module tb_autosym_eval;
  localparam int N  = 6;
  localparam int K  = 3;
  localparam int AW = (K > 1) ? $clog2(K) : 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0, out_ready = 1'b1;
  logic [N-1:0]  x = '0;
  logic          cfg_row_we = 1'b0, cfg_tt_we = 1'b0, cfg_tt_data = 1'b0;
  logic          cfg_inv_we = 1'b0, cfg_inv_data = 1'b0;
  logic [AW-1:0] cfg_row_addr = '0;
  logic [N-1:0]  cfg_row_data = '0;
  logic [K-1:0]  cfg_tt_addr = '0;
  logic          in_ready, out_valid, y, cfg_ready;
  logic [15:0]   ones_count;
  logic          in_ready2, out_valid2, y2, cfg_ready2;
  logic [1:0]    ones_count2;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  autosym_eval #(.N(N), .K(K), .CW(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .x(x),
    .out_valid(out_valid), .out_ready(out_ready), .y(y),
    .cfg_row_we(cfg_row_we), .cfg_row_addr(cfg_row_addr), .cfg_row_data(cfg_row_data),
    .cfg_tt_we(cfg_tt_we), .cfg_tt_addr(cfg_tt_addr), .cfg_tt_data(cfg_tt_data),
    .cfg_inv_we(cfg_inv_we), .cfg_inv_data(cfg_inv_data),
    .cfg_ready(cfg_ready), .ones_count(ones_count));

  autosym_eval #(.N(N), .K(K), .CW(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2), .x(x),
    .out_valid(out_valid2), .out_ready(out_ready), .y(y2),
    .cfg_row_we(cfg_row_we), .cfg_row_addr(cfg_row_addr), .cfg_row_data(cfg_row_data),
    .cfg_tt_we(cfg_tt_we), .cfg_tt_addr(cfg_tt_addr), .cfg_tt_data(cfg_tt_data),
    .cfg_inv_we(cfg_inv_we), .cfg_inv_data(cfg_inv_data),
    .cfg_ready(cfg_ready2), .ones_count(ones_count2));

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit [N-1:0] rows_m [K];
  bit [7:0]   tt_m;
  bit         inv_m;
  bit         exp_q [$];
  int         cnt_m;
  bit         prev_stall;

  function automatic void model_reset();
    for (int j = 0; j < K; j++) rows_m[j] = N'(1) << j;
    tt_m = '0; inv_m = 0; cnt_m = 0; prev_stall = 0;
    exp_q.delete();
  endfunction

  function automatic bit model_y(input bit [N-1:0] xv);
    bit [K-1:0] z;
    for (int j = 0; j < K; j++) begin
      z[j] = 0;
      for (int i = 0; i < N; i++) z[j] = z[j] ^ (rows_m[j][i] & xv[i]);
    end
    return tt_m[z] ^ inv_m;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_out_valid", out_valid, 0);
      check("rst_y", y, 0);
      check("rst_ones", ones_count, 0);
      check("rst_in_ready", in_ready, 0);
      check("rst_cfg_ready", cfg_ready, 0);
      model_reset();
    end else begin
      check("ones", ones_count, cnt_m);
      check("ones_sat", ones_count2, (cnt_m > 3) ? 3 : cnt_m);
      check("twin", {in_ready2, out_valid2, y2, cfg_ready2}, {in_ready, out_valid, y, cfg_ready});
      if (prev_stall) check("hold_valid", out_valid, 1);
      prev_stall = out_valid && !out_ready;
      if (cfg_ready) check("cfg_rdy_empty", exp_q.size(), 0);
      if (cfg_row_we || cfg_tt_we || cfg_inv_we) check("in_rdy_cfg", in_ready, 0);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("spurious_out", 1, 0);
        else begin
          bit e;
          e = exp_q.pop_front();
          check("y", y, e);
          if (e) cnt_m++;
        end
      end
      if (cfg_ready && (cfg_row_we || cfg_tt_we || cfg_inv_we)) begin
        if (cfg_row_we && cfg_row_addr < K) rows_m[cfg_row_addr] = cfg_row_data;
        if (cfg_tt_we)  tt_m[cfg_tt_addr] = cfg_tt_data;
        if (cfg_inv_we) inv_m = cfg_inv_data;
      end
      if (in_valid && in_ready) exp_q.push_back(model_y(x));
    end
  end

  // ---------------- drivers ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [N-1:0] xv);
    bit ok;
    ok = 0;
    in_valid = 1; x = xv;
    for (int c = 0; c < 50 && !ok; c++) begin
      @(negedge clk); ok = in_ready;
      step();
    end
    in_valid = 0;
    if (!ok) check("send_timeout", 0, 1);
  endtask

  task automatic cfg(input bit rwe, input logic [AW-1:0] ra, input logic [N-1:0] rd,
                     input bit twe, input logic [K-1:0] ta, input bit td,
                     input bit iwe, input bit id);
    bit ok;
    ok = 0;
    cfg_row_we = rwe; cfg_row_addr = ra; cfg_row_data = rd;
    cfg_tt_we = twe; cfg_tt_addr = ta; cfg_tt_data = td;
    cfg_inv_we = iwe; cfg_inv_data = id;
    for (int c = 0; c < 50 && !ok; c++) begin
      @(negedge clk); ok = cfg_ready;
      step();
    end
    cfg_row_we = 0; cfg_tt_we = 0; cfg_inv_we = 0;
    if (!ok) check("cfg_timeout", 0, 1);
  endtask

  // Pipeline must be empty; checks the two-cycle latency and the literal result.
  task automatic send_expect(input logic [N-1:0] xv, input bit ey);
    send(xv);
    @(negedge clk); check("lat_c1_valid", out_valid, 0);
    @(negedge clk); check("lat_c2_valid", out_valid, 1);
    check("lit_y", y, ey);
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) step();
    rst_n = 1;
    @(negedge clk);
    check("post_rst_in_ready", in_ready, 1);
    check("post_rst_cfg_ready", cfg_ready, 1);
    step();

    // TT[5]=1, identity rows: x=000101 -> z=101 -> y=1
    cfg(0, '0, '0, 1, 3'd5, 1, 0, 0);
    send_expect(6'b000101, 1);
    @(negedge clk); check("lit_ones1", ones_count, 1);
    step();

    // ROW[0]=110000: x=010000 -> z=001 -> TT[1]=0; then inv=1 -> 1
    cfg(1, 2'd0, 6'b110000, 0, '0, 0, 0, 0);
    send_expect(6'b010000, 0);
    cfg(0, '0, '0, 0, '0, 0, 1, 1);
    send_expect(6'b010000, 1);

    // Back-to-back stream with a consumer stall in cycles 2-4
    fork
      begin
        for (int v = 1; v <= 5; v++) send(N'(v));
      end
      begin
        repeat (2) step();
        out_ready = 0;
        @(negedge clk);
        check("stall_in_ready", in_ready, 0);
        check("stall_out_valid", out_valid, 1);
        repeat (3) step();
        out_ready = 1;
      end
    join
    repeat (6) step();
    check("stream_drained", exp_q.size(), 0);

    // Two in flight (x=0 -> old TT[0]^inv = 1), then TT[0]=1 with an input waiting
    send(6'b000000);
    send(6'b000000);
    in_valid = 1; x = 6'b000000;
    cfg_tt_we = 1; cfg_tt_addr = 3'd0; cfg_tt_data = 1;
    @(negedge clk);
    check("inflight_cfg_ready", cfg_ready, 0);
    check("inflight_in_ready", in_ready, 0);
    step();
    cfg(0, '0, '0, 1, 3'd0, 1, 0, 0);
    @(negedge clk); check("cfg_then_in", in_ready, 1);
    step();
    in_valid = 0;
    repeat (4) step();
    send_expect(6'b000000, 0);

    // Reset while a result is stalled at the output
    out_ready = 0;
    send(6'b000101);
    step();
    @(negedge clk); check("pre_rst_valid", out_valid, 1);
    #2 rst_n = 0;
    #1;
    check("async_rst_valid", out_valid, 0);
    check("async_rst_ones", ones_count, 0);
    step();
    step();
    rst_n = 1;
    out_ready = 1;
    @(negedge clk);
    check("rel_in_ready", in_ready, 1);
    check("rel_cfg_ready", cfg_ready, 1);
    step();
    send_expect(6'b000101, 0);

    // Out-of-range row write is ignored; combined row+TT write in one cycle
    cfg(1, 2'd3, 6'b111111, 1, 3'd1, 1, 0, 0);
    send_expect(6'b000001, 1);
    for (int v = 0; v < 4; v++) send(6'b000001);
    repeat (4) step();
    @(negedge clk);
    check("lit_ones5", ones_count, 5);
    check("lit_ones_sat", ones_count2, 3);
    check("final_drained", exp_q.size(), 0);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/autosym_eval.md
AUTOSYM_EVAL -- requirements
Module: autosym_eval

Interface
REQ-001 Parameter N, default 6: width of the input vector x.
REQ-002 Parameter K, default 3: width of the reduced (projected) vector; SHALL satisfy 1 <= K <= N, with elaboration failing otherwise.
REQ-003 Parameter CW, default 16: width of the ones counter.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 in_valid  input  1  x is presented.
REQ-007 in_ready  output  1  block accepts x this cycle.
REQ-008 x  input  N  input vector (bit i = variable xi).
REQ-009 out_valid  output  1  y is valid.
REQ-010 out_ready  input  1  consumer accepts y.
REQ-011 y  output  1  function value for the accepted x.
REQ-012 cfg_row_we  input  1  write one projection-matrix row.
REQ-013 cfg_row_addr  input  max(1,clog2(K))  row index 0..K-1; indices >= K ignored.
REQ-014 cfg_row_data  input  N  row mask over x.
REQ-015 cfg_tt_we  input  1  write one truth-table bit.
REQ-016 cfg_tt_addr  input  K  truth-table index.
REQ-017 cfg_tt_data  input  1  truth-table bit.
REQ-018 cfg_inv_we, cfg_inv_data  input  1,1  write the output-complement flag.
REQ-019 cfg_ready  output  1  config writes accepted this cycle.
REQ-020 ones_count  output  CW  number of y=1 results delivered since reset.

Function
REQ-021 Evaluation SHALL compute y = TT[z] XOR inv, where z[j] = XOR over i of (ROW[j][i] AND x[i]) for j = 0..K-1, i.e. a GF(2) linear projection followed by a 2^K-entry lookup.
REQ-022 The pipeline SHALL have two stages: stage 1 registers z; stage 2 registers y. Latency from the accepting cycle (in_valid & in_ready) to out_valid is 2 cycles when out_ready is held high.
REQ-023 Throughput SHALL be one result per cycle when out_ready is held high.
REQ-024 Each stage SHALL advance when it is empty or when its downstream consumer accepts. in_ready = !cfg_pending & (!s1_valid | s1_advance).
REQ-025 When out_ready is low, y and out_valid SHALL hold. No vector is dropped or duplicated, and order is preserved.
REQ-026 cfg_ready SHALL be 1 only when both stages are empty. A config write presented while cfg_ready=0 is held by the source and applied only when cfg_ready=1.
REQ-027 cfg_pending (any cfg_*_we high) SHALL force in_ready=0. A config write therefore wins over a simultaneous input. The input is accepted the cycle after the writes deassert.
REQ-028 Multiple cfg_*_we asserted in the same accepted cycle SHALL all take effect in that cycle.
REQ-029 New configuration SHALL affect only vectors accepted after the write cycle.
REQ-030 ones_count SHALL increment on each out_valid & out_ready with y=1, and SHALL saturate at 2^CW-1 with no wrap.

Reset
REQ-031 While rst_n=0, all of the following SHALL hold: out_valid=0, y=0, ones_count=0, stage valids=0, inv=0, TT = all zeros, and ROW[j] = one-hot at bit j (identity on x[K-1:0]). in_ready=0 and cfg_ready=0 while reset is asserted.
REQ-032 Reset assertion mid-operation SHALL discard in-flight vectors immediately (asynchronously). in_ready and cfg_ready SHALL be 1 in the first cycle after release.

Verification
REQ-033 Reset, write TT[5]=1, then x=6'b000101 with out_ready=1 -> z=3'b101, y=1 and out_valid exactly 2 cycles after acceptance, ones_count=1.
REQ-034 Write ROW[0]=6'b110000, then x=6'b010000 -> z=3'b001, y=TT[1]=0. Then write inv=1 and repeat the same x -> y=1.
REQ-035 Stream x=1,2,3,4,5 back-to-back with out_ready low for cycles 2-4 -> in_ready drops once both stages are full, and all 5 results emerge in order with none lost or repeated.
REQ-036 Assert cfg_tt_we while 2 vectors are in flight -> cfg_ready=0 and in_ready=0 until the pipeline drains. The write then applies, and the in-flight results use the old TT.
REQ-037 Pulse rst_n low while out_valid=1 and out_ready=0 -> out_valid=0, ones_count=0, and the tables return to identity/zero. An x=6'b000101 evaluated after release gives y=0.
REQ-038 With CW=2, deliver 5 results with y=1 -> ones_count reads 1,2,3,3,3.
